// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared types and constants for the LED slide sequencer.
//   state_t      FSM states IDLE / RUN / PAUSE
//   SPD_*        SW speed codes
//   DIV_X2/X5    period divisors for the fast speeds
package led_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    localparam logic [1:0] SPD_STOP = 2'b00;
    localparam logic [1:0] SPD_SLOW = 2'b01;
    localparam logic [1:0] SPD_X2   = 2'b10;
    localparam logic [1:0] SPD_X5   = 2'b11;
    localparam int DIV_X2 = 2;
    localparam int DIV_X5 = 5;
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: switch-selected step strobe derived from clk, no generated clocks.
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   SW    in   speed select (00 stop, 01 slow, 10 x2, 11 x5)
//   tick  out  one-cycle strobe when the counter reaches period-1
module led_tick_gen
    import led_ctrl_pkg::*;
#(
    parameter int MAX_CNT_DEST = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] SW,
    output logic       tick
);
    localparam int CW = $clog2(MAX_CNT_DEST + 1);
    logic [CW-1:0] cnt;
    logic [CW-1:0] period;
    logic [1:0]    sw_q;
    logic          changed;
    always_comb begin
        period  = SW == SPD_X5 ? CW'(MAX_CNT_DEST / DIV_X5) :
                  SW == SPD_X2 ? CW'(MAX_CNT_DEST / DIV_X2) : CW'(MAX_CNT_DEST);
        changed = SW != sw_q;
        // a speed change restarts the period instead of ticking
        tick    = SW != SPD_STOP && !changed && cnt == period - 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_q <= SPD_STOP;
            cnt  <= '0;
        end else begin
            sw_q <= SW;
            cnt  <= (SW == SPD_STOP || changed || tick) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/led_slide_ctrl.sv
// led_slide_ctrl: RUN/PAUSE sequencer sliding a one-hot LED across the LED bank.
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   SW         in   speed select (00 stop, 01 slow, 10 x2, 11 x5)
//   btn_pause  in   one-cycle pulse, toggles RUN/PAUSE
//   btn_dir    in   one-cycle pulse, reverses direction
//   LED        out  registered one-hot display
//   pos        out  index of the lit LED
//   dir        out  0 = pos increments, 1 = pos decrements
//   step       out  one-cycle strobe in the cycle LED/pos update
//   running    out  1 while in RUN
// Build option: define LED_BOUNCE_EN for ping-pong at the ends instead of wrap-around.
module led_slide_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int MAX_CNT_DEST = 5000000,
    parameter int NUM_LED      = 16,
    localparam int PW          = $clog2(NUM_LED)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         SW,
    input  logic               btn_pause,
    input  logic               btn_dir,
    output logic [NUM_LED-1:0] LED,
    output logic [PW-1:0]      pos,
    output logic               dir,
    output logic               step,
    output logic               running
);
    localparam logic [PW-1:0] LAST = PW'(NUM_LED - 1);
    state_t        state;
    state_t        state_nxt;
    logic          tick;
    logic          do_step;
    logic          bounce;
    logic [PW-1:0] pos_nxt;

    led_tick_gen #(.MAX_CNT_DEST(MAX_CNT_DEST)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .SW   (SW),
        .tick (tick)
    );

    always_comb begin
        // pause wins over a coincident tick
        do_step   = state == RUN && tick && !btn_pause;
`ifdef LED_BOUNCE_EN
        bounce    = dir ? pos == '0 : pos == LAST;
        pos_nxt   = dir ? (bounce ? PW'(1) : pos - 1'b1) : (bounce ? LAST - 1'b1 : pos + 1'b1);
`else
        bounce    = 1'b0;
        pos_nxt   = dir ? (pos == '0 ? LAST : pos - 1'b1) : (pos == LAST ? '0 : pos + 1'b1);
`endif
        state_nxt = state == IDLE ? (SW != SPD_STOP ? RUN : IDLE) :
                    btn_pause ? (state == RUN ? PAUSE : RUN) : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            running <= 1'b0;
            step    <= 1'b0;
            dir     <= 1'b0;
            pos     <= '0;
            LED     <= NUM_LED'(1);
        end else begin
            state   <= state_nxt;
            running <= state_nxt == RUN;
            step    <= do_step;
            // step uses the old dir; a bounce flip and a button press cancel
            dir     <= dir ^ btn_dir ^ (do_step & bounce);
            if (do_step) begin
                pos <= pos_nxt;
                LED <= NUM_LED'(1) << pos_nxt;
            end
        end
    end
endmodule

// File: tb/tb_led_slide_ctrl.sv
// tb_led_slide_ctrl: directed scoreboard bench for led_slide_ctrl with MAX_CNT_DEST=20.
module tb_led_slide_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  SW = 2'b00;
    logic        btn_pause = 1'b0;
    logic        btn_dir = 1'b0;
    logic [15:0] LED;
    logic [3:0]  pos;
    logic        dir;
    logic        step;
    logic        running;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic [3:0] pos;
        logic       dir;
    } exp_t;
    exp_t sb[$];
    logic [3:0] exp_pos = 4'd0;
    logic       exp_dir = 1'b0;

    always #5 clk = ~clk;

    led_slide_ctrl #(.MAX_CNT_DEST(20), .NUM_LED(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .SW        (SW),
        .btn_pause (btn_pause),
        .btn_dir   (btn_dir),
        .LED       (LED),
        .pos       (pos),
        .dir       (dir),
        .step      (step),
        .running   (running)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference step: advance the model and queue what the DUT must show after the step
    task automatic push_step(input logic dtog);
        logic flip;
        flip = 1'b0;
        if (!exp_dir) begin
            if (exp_pos == 4'd15) begin
`ifdef LED_BOUNCE_EN
                exp_pos = 4'd14;
                flip = 1'b1;
`else
                exp_pos = 4'd0;
`endif
            end else exp_pos = exp_pos + 4'd1;
        end else begin
            if (exp_pos == 4'd0) begin
`ifdef LED_BOUNCE_EN
                exp_pos = 4'd1;
                flip = 1'b1;
`else
                exp_pos = 4'd15;
`endif
            end else exp_pos = exp_pos - 4'd1;
        end
        exp_dir = exp_dir ^ flip ^ dtog;
        sb.push_back('{exp_pos, exp_dir});
    endtask

    task automatic wait_step(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (step !== 1'b1 && cyc < budget);
        chk("step_within_budget", 32'(step), 32'(1));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_led"}, 32'(LED), 32'h0001);
        chk({tag, "_pos"}, 32'(pos), 32'(0));
        chk({tag, "_dir"}, 32'(dir), 32'(0));
        chk({tag, "_step"}, 32'(step), 32'(0));
        chk({tag, "_running"}, 32'(running), 32'(0));
    endtask

    // every observed step pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && step === 1'b1) begin
            chk("step_expected", 32'(sb.size() > 0), 32'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("step_pos", 32'(pos), 32'(e.pos));
                chk("step_led", 32'(LED), 32'(16'(1) << e.pos));
                chk("step_dir", 32'(dir), 32'(e.dir));
            end
        end
    end

    initial begin
        int c;
        int g;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        SW = 2'b01;
        for (int i = 0; i < 17; i++) push_step(1'b0);
        wait_step(30, c);
        chk("slow_first_interval", 32'(c), 32'(21));
        chk("running_after_start", 32'(running), 32'(1));
        for (int i = 1; i < 17; i++) begin
            wait_step(30, c);
            chk("slow_interval", 32'(c), 32'(20));
        end
        repeat (7) @(negedge clk);
        SW = 2'b11;
        for (int i = 0; i < 3; i++) push_step(1'b0);
        wait_step(10, c);
        chk("x5_first_interval", 32'(c), 32'(5));
        for (int i = 1; i < 3; i++) begin
            wait_step(10, c);
            chk("x5_interval", 32'(c), 32'(4));
        end
        SW = 2'b10;
        push_step(1'b0);
        push_step(1'b0);
        wait_step(15, c);
        chk("x2_first_interval", 32'(c), 32'(11));
        wait_step(15, c);
        chk("x2_interval", 32'(c), 32'(10));
        SW = 2'b00;
        repeat (50) @(negedge clk);
        chk("stop_led_hold", 32'(LED), 32'(16'(1) << exp_pos));
        chk("stop_pos_hold", 32'(pos), 32'(exp_pos));
        chk("stop_running", 32'(running), 32'(1));
        SW = 2'b01;
        repeat (20) @(negedge clk);
        btn_pause = 1'b1;
        @(negedge clk);
        btn_pause = 1'b0;
        chk("pause_no_step", 32'(step), 32'(0));
        chk("pause_running", 32'(running), 32'(0));
        chk("pause_pos", 32'(pos), 32'(exp_pos));
        repeat (25) @(negedge clk);
        chk("paused_pos_hold", 32'(pos), 32'(exp_pos));
        btn_pause = 1'b1;
        @(negedge clk);
        btn_pause = 1'b0;
        chk("resume_running", 32'(running), 32'(1));
        push_step(1'b0);
        wait_step(25, c);
        SW = 2'b11;
        g = 0;
        while (exp_pos != 4'd0 && g < 40) begin
            push_step(1'b0);
            wait_step(10, c);
            g++;
        end
        chk("reached_pos0", 32'(pos), 32'(0));
        btn_dir = 1'b1;
        @(negedge clk);
        btn_dir = 1'b0;
        exp_dir = ~exp_dir;
        chk("dir_toggle", 32'(dir), 32'(exp_dir));
        push_step(1'b0);
        wait_step(10, c);
        push_step(1'b0);
        wait_step(10, c);
        repeat (3) @(negedge clk);
        btn_dir = 1'b1;
        push_step(1'b1);
        @(negedge clk);
        btn_dir = 1'b0;
        chk("dir_coincident_step", 32'(step), 32'(1));
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset("async_reset");
        @(negedge clk);
        rst = 1'b0;
        exp_pos = 4'd0;
        exp_dir = 1'b0;
        push_step(1'b0);
        wait_step(10, c);
        chk("restart_interval", 32'(c), 32'(5));
        chk("restart_running", 32'(running), 32'(1));
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
